ctrl_fsm: RTL

Multicycle control unit that drives the datapath control inputs of the fetch, decode, execute and memory stages, including the decode stage's `RF_WrEn`, `RF_WrData_sel` and `RF_B_sel`. It steps each instruction through FETCH, DECODE and the per-class execute, memory and writeback states. It asserts exactly one PC update per retired instruction and parks in a trap state on an unknown opcode.

---
 rtl/ctrl_fsm_if.sv | 37 +++
 rtl/ctrl_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_if.sv
// Control bundle between the multicycle controller and the datapath it steers.
// Instr_cnt exists only when CTRL_PERF_CNT_EN is defined.
interface ctrl_fsm_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        IR_LdEn;
  logic        PC_LdEn;
  logic        PC_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        RF_B_sel;
  logic        RF_WrData_sel;
  logic        RF_WrEn;
  logic        MEM_WrEn;
  logic        Illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] Instr_cnt;
`endif

  modport master (
    input  Instr, Zero,
    output IR_LdEn, PC_LdEn, PC_sel, ALU_Bin_sel, ALU_func,
           RF_B_sel, RF_WrData_sel, RF_WrEn, MEM_WrEn, Illegal
`ifdef CTRL_PERF_CNT_EN
    , output Instr_cnt
`endif
  );

  modport slave (
    output Instr, Zero,
    input  IR_LdEn, PC_LdEn, PC_sel, ALU_Bin_sel, ALU_func,
           RF_B_sel, RF_WrData_sel, RF_WrEn, MEM_WrEn, Illegal
`ifdef CTRL_PERF_CNT_EN
    , input Instr_cnt
`endif
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Multicycle control unit: FETCH, DECODE, then per-class execute/memory/writeback.
// Optional retired-instruction counter enabled by CTRL_PERF_CNT_EN.
//
// state    | meaning
// FETCH    | load IR from instruction memory
// DECODE   | opcode dispatch, no enables
// EXEC_R   | R-type ALU operation, func from Instr[3:0]
// EXEC_I   | immediate ALU operation
// MEM_ADDR | effective address = rs + Immed
// MEM_RD   | data memory read, address held
// MEM_WR   | data memory write and PC update
// WB_ALU   | write ALU result, PC update
// WB_MEM   | write load data, PC update
// BRANCH   | unconditional PC+4+Immed
// BR_CMP   | compare via sub, conditional PC update
// TRAP     | unknown opcode, parked until Reset
module ctrl_fsm (
  input  logic         Clk,
  input  logic         Reset,
  ctrl_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_BR_CMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;

  state_e     state_q, state_d;
  logic [5:0] opcode;
  logic [3:0] imm_func;
  logic       is_load;
  logic       unused_instr;

  logic       ir_ld_en, pc_ld_en, pc_sel, alu_bin_sel, rf_b_sel;
  logic       rf_wr_data_sel, rf_wr_en, mem_wr_en, illegal;
  logic [3:0] alu_func;

  assign opcode       = bus.Instr[31:26];
  assign unused_instr = ^bus.Instr[25:4];
  assign is_load      = (opcode == OP_LB) || (opcode == OP_LW);

  always_comb begin
    case (opcode)
      OP_ANDI: imm_func = FN_AND;
      OP_ORI:  imm_func = FN_OR;
      default: imm_func = FN_ADD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ir_ld_en       = 1'b0;
    pc_ld_en       = 1'b0;
    pc_sel         = 1'b0;
    alu_bin_sel    = 1'b0;
    alu_func       = FN_ADD;
    rf_b_sel       = 1'b0;
    rf_wr_data_sel = 1'b0;
    rf_wr_en       = 1'b0;
    mem_wr_en      = 1'b0;
    illegal        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_ld_en = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_LI, OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
          OP_LB, OP_LW, OP_SB, OP_SW:       state_d = S_MEM_ADDR;
          OP_B:                             state_d = S_BRANCH;
          OP_BEQ, OP_BNE:                   state_d = S_BR_CMP;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_func = bus.Instr[3:0];
        state_d  = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_bin_sel = 1'b1;
        alu_func    = imm_func;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        // Instr is stable here, so the execute-state ALU controls are re-derived.
        if (opcode == OP_RTYPE) begin
          alu_func = bus.Instr[3:0];
        end else begin
          alu_bin_sel = 1'b1;
          alu_func    = imm_func;
        end
        rf_wr_data_sel = 1'b1;
        rf_wr_en       = 1'b1;
        pc_ld_en       = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        state_d     = is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        state_d     = S_WB_MEM;
      end
      S_WB_MEM: begin
        rf_wr_en = 1'b1;
        pc_ld_en = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        mem_wr_en   = 1'b1;
        pc_ld_en    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        pc_ld_en = 1'b1;
        pc_sel   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR_CMP: begin
        rf_b_sel = 1'b1;
        alu_func = FN_SUB;
        pc_ld_en = 1'b1;
        pc_sel   = (opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
    // Reset gates every output so an interrupted write never reaches the datapath.
    if (Reset) begin
      ir_ld_en       = 1'b0;
      pc_ld_en       = 1'b0;
      pc_sel         = 1'b0;
      alu_bin_sel    = 1'b0;
      alu_func       = FN_ADD;
      rf_b_sel       = 1'b0;
      rf_wr_data_sel = 1'b0;
      rf_wr_en       = 1'b0;
      mem_wr_en      = 1'b0;
      illegal        = 1'b0;
    end
  end

  assign bus.IR_LdEn       = ir_ld_en;
  assign bus.PC_LdEn       = pc_ld_en;
  assign bus.PC_sel        = pc_sel;
  assign bus.ALU_Bin_sel   = alu_bin_sel;
  assign bus.ALU_func      = alu_func;
  assign bus.RF_B_sel      = rf_b_sel;
  assign bus.RF_WrData_sel = rf_wr_data_sel;
  assign bus.RF_WrEn       = rf_wr_en;
  assign bus.MEM_WrEn      = mem_wr_en;
  assign bus.Illegal       = illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset)                              instr_cnt_q <= '0;
    else if (pc_ld_en && state_q != S_TRAP) instr_cnt_q <= instr_cnt_q + 32'd1;
  end

  assign bus.Instr_cnt = instr_cnt_q;
`endif

endmodule
